dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- N-channel data-memory arbiter in front of the single processor data-memory port.
- Generalises the current two-source mux (processor dmem plus the external Cocotb port) to NREQ requesters, with two arbitration modes, a configurable memory read latency and per-channel response routing.
- Keeps one request outstanding at a time and uses a val/rdy request handshake; responses are returned to the requester that issued them.

Parameters:
- NREQ, 2: number of requester channels (>=2).
- AW, 32: address width.
- DW, 32: data width.
- MEM_LAT, 0: cycles from memory request acceptance to valid mem_resp_rdata. 0 means a combinational read in the same cycle.
- RR_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- req_val  input  NREQ  per-channel request valid
- req_rdy  output  NREQ  per-channel request accepted this cycle
- req_type  input  NREQ  per-channel 0=read, 1=write
- req_addr  input  NREQ*AW  per-channel address; channel i in bits [i*AW +: AW]
- req_wdata  input  NREQ*DW  per-channel write data; channel i in bits [i*DW +: DW]
- resp_val  output  NREQ  one-hot, one-cycle response strobe to the owning channel
- resp_rdata  output  DW  registered response data (shared by all channels)
- mem_req_val  output  1  memory request valid
- mem_req_type  output  1  memory request type
- mem_req_addr  output  AW  memory address
- mem_req_wdata  output  DW  memory write data
- mem_resp_rdata  input  DW  memory read data
- busy  output  1  a request is outstanding (state is not IDLE)

Behaviour:
- Reset (rst=0, asynchronous) clears all state:
  - state = IDLE; latency counter = 0; owner = 0.
  - RR pointer = NREQ-1, so channel 0 has first priority.
  - resp_val = 0; resp_rdata = 0; busy = 0.
  - req_rdy and mem_req_val are forced to 0 while rst=0.
- Any outstanding transaction is dropped on reset: no resp_val is issued for it after reset deasserts.
- States:
  - IDLE: no transaction outstanding.
  - WAIT: counting memory latency; entered only when MEM_LAT>0.
  - RESP: resp_val asserted this cycle.
- Grant: computed combinationally in IDLE and RESP only; in WAIT all req_rdy = 0.
  - Fixed mode: lowest index with req_val=1 wins.
  - RR mode: the search starts at pointer+1 modulo NREQ; the pointer is updated to the winner only on an accepted grant.
- Acceptance, cycle t:
  - req_rdy[g]=1 only for the winner g; every other req_rdy bit is 0.
  - mem_req_val=1 and mem_req_* carry channel g's fields combinationally; memory samples them at the edge ending cycle t.
  - When no grant is made, mem_req_val=0 and mem_req_type/addr/wdata=0.
- Transitions after acceptance:
  - MEM_LAT=0: capture mem_resp_rdata at the end of cycle t, then go to RESP.
  - MEM_LAT>0: go to WAIT and count; in cycle t+MEM_LAT capture mem_resp_rdata, then go to RESP.
- Response: resp_val[owner]=1 for exactly one cycle (t+MEM_LAT+1); resp_rdata holds the captured data.
  - Writes also get a resp_val acknowledge, with resp_rdata = 0.
  - resp_rdata holds its value until the next capture.
- RESP with a new grant goes to WAIT/RESP per MEM_LAT; RESP with no grant goes to IDLE; IDLE with no grant stays in IDLE.
- Throughput: one transaction per MEM_LAT+1 cycles; back-to-back with MEM_LAT=0.
- Requester rules:
  - Hold req_val and payload stable until req_rdy is seen.
  - A losing channel stays pending and is not dropped.
  - req_val deasserted before req_rdy is legal; that request is not issued.
- Simultaneous response and new grant in RESP: the resp_val owner and the new grantee may be the same channel. Both strobes are legal in the same cycle.
- busy = 1 in WAIT and RESP.
- Counter width is $clog2(MEM_LAT+1); it does not wrap because it is cleared on entry to WAIT.

Test Plan:
- Reset, then idle with all req_val=0: resp_val=0, mem_req_val=0, busy=0, resp_rdata=0.
- NREQ=2, MEM_LAT=0, fixed mode:
  - ch0 write addr 0x100 data 0xDEADBEEF, then ch1 read 0x100.
  - Expect ch1 resp_rdata=0xDEADBEEF one cycle after acceptance, with resp_val=2'b10.
- Fixed mode, ch0 and ch1 both requesting continuously: ch0 granted every cycle and ch1 starved; after ch0 drops, ch1 is granted the next cycle.
- RR mode, NREQ=4, all four valid for 8 cycles: grant order is 0,1,2,3,0,1,2,3, and every resp_val goes to the matching owner.
- MEM_LAT=3, ch2 reads 0x40 holding 0x1234:
  - req_rdy=0 for all channels during the 3 WAIT cycles; busy=1.
  - resp_val[2]=1 with 0x1234 at t+4.
- MEM_LAT=3, rst pulsed low in the second WAIT cycle: state returns to IDLE immediately; no resp_val after release; the RR pointer restarts at channel 0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side signal bundle for dmem_arbiter.
// The arbiter takes the slave view; requesters plus the memory model take the master view.
interface dmem_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_val;
    logic [NREQ-1:0]    req_rdy;
    logic [NREQ-1:0]    req_type;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    resp_val;
    logic [DW-1:0]      resp_rdata;
    logic               mem_req_val;
    logic               mem_req_type;
    logic [AW-1:0]      mem_req_addr;
    logic [DW-1:0]      mem_req_wdata;
    logic [DW-1:0]      mem_resp_rdata;
    logic               busy;

    modport slave (
        input  req_val, req_type, req_addr, req_wdata, mem_resp_rdata,
        output req_rdy, resp_val, resp_rdata,
               mem_req_val, mem_req_type, mem_req_addr, mem_req_wdata, busy
    );

    modport master (
        output req_val, req_type, req_addr, req_wdata, mem_resp_rdata,
        input  req_rdy, resp_val, resp_rdata,
               mem_req_val, mem_req_type, mem_req_addr, mem_req_wdata, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// N-channel data-memory arbiter: one outstanding request, fixed-priority or round-robin grant,
// configurable memory read latency, response strobed back to the owning channel.
module dmem_arbiter #(
    parameter int NREQ    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 0,
    parameter int RR_MODE = 0
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW     = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam int LAST_I = (MEM_LAT > 0) ? MEM_LAT - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(LAST_I);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [IW-1:0] owner_reg, owner_next;
    logic [IW-1:0] rr_ptr_reg, rr_ptr_next;
    logic          type_reg, type_next;
    logic [DW-1:0] rdata_reg, rdata_next;

    logic          can_grant;
    logic          gnt_any;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] scan_sel;
    int            scan_idx;

    // Grants are gated by reset so nothing is accepted while rst is low.
    assign can_grant = rst && (state_reg != WAIT);

    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = 0;
        scan_sel = '0;
        if (can_grant) begin
            for (int k = 0; k < NREQ; k++) begin
                scan_idx = (RR_MODE != 0) ? (int'(rr_ptr_reg) + 1 + k) % NREQ : k;
                scan_sel = IW'(scan_idx);
                if (!gnt_any && bus.req_val[scan_sel]) begin
                    gnt_any = 1'b1;
                    gnt_idx = scan_sel;
                end
            end
        end
    end

    always_comb begin
        bus.mem_req_val   = gnt_any;
        bus.mem_req_type  = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_req_wdata = '0;
        if (gnt_any) begin
            bus.mem_req_type  = bus.req_type[gnt_idx];
            bus.mem_req_addr  = bus.req_addr[gnt_idx*AW +: AW];
            bus.mem_req_wdata = bus.req_wdata[gnt_idx*DW +: DW];
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_chan
        assign bus.req_rdy[gi]  = gnt_any && (gnt_idx == IW'(gi));
        assign bus.resp_val[gi] = (state_reg == RESP) && (owner_reg == IW'(gi));
    end

    assign bus.resp_rdata = rdata_reg;
    assign bus.busy       = (state_reg != IDLE);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        type_next   = type_reg;
        rdata_next  = rdata_reg;
        case (state_reg)
            IDLE, RESP: begin
                if (gnt_any) begin
                    owner_next  = gnt_idx;
                    rr_ptr_next = gnt_idx;
                    type_next   = bus.req_type[gnt_idx];
                    if (MEM_LAT == 0) begin
                        state_next = RESP;
                        // Writes are acknowledged with zero data.
                        rdata_next = bus.req_type[gnt_idx] ? '0 : bus.mem_resp_rdata;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = '0;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = RESP;
                    rdata_next = type_reg ? '0 : bus.mem_resp_rdata;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pointer resets to the last channel so channel 0 is searched first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            owner_reg  <= '0;
            rr_ptr_reg <= IW'(NREQ - 1);
            type_reg   <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
            type_reg   <= type_next;
            rdata_reg  <= rdata_next;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: fixed/LAT0 (a), round-robin/LAT0 (b), round-robin/LAT3 (c).
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.NREQ(2), .AW(32), .DW(32)) bus_a ();
    dmem_arbiter_if #(.NREQ(4), .AW(32), .DW(32)) bus_b ();
    dmem_arbiter_if #(.NREQ(4), .AW(32), .DW(32)) bus_c ();

    dmem_arbiter #(.NREQ(2), .AW(32), .DW(32), .MEM_LAT(0), .RR_MODE(0)) u_fix (
        .clk(clk), .rst(rst_n), .bus(bus_a));
    dmem_arbiter #(.NREQ(4), .AW(32), .DW(32), .MEM_LAT(0), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst_n), .bus(bus_b));
    dmem_arbiter #(.NREQ(4), .AW(32), .DW(32), .MEM_LAT(3), .RR_MODE(1)) u_lat (
        .clk(clk), .rst(rst_n), .bus(bus_c));

    // Memory a: writable RAM with combinational read.
    logic [31:0] mem_a [0:255] = '{default: 32'h0};
    assign bus_a.mem_resp_rdata = (bus_a.mem_req_val && !bus_a.mem_req_type) ?
                                  mem_a[bus_a.mem_req_addr[9:2]] : 32'h0;
    always @(posedge clk)
        if (bus_a.mem_req_val && bus_a.mem_req_type)
            mem_a[bus_a.mem_req_addr[9:2]] <= bus_a.mem_req_wdata;

    // Memory b: read-only pattern, word i holds 0xA0+i.
    assign bus_b.mem_resp_rdata = (bus_b.mem_req_val && !bus_b.mem_req_type) ?
                                  (32'hA0 + {24'h0, bus_b.mem_req_addr[9:2]}) : 32'h0;

    // Memory c: read data appears exactly three cycles after acceptance.
    function automatic logic [31:0] rom_c(input logic [7:0] idx);
        if (idx == 8'h10) return 32'h1234;
        if (idx == 8'h00) return 32'h55;
        return 32'h0;
    endfunction
    logic [2:0]  pv_c = 3'b000;
    logic [31:0] pd_c [0:2] = '{default: 32'h0};
    assign bus_c.mem_resp_rdata = pv_c[2] ? pd_c[2] : 32'h0;
    always @(posedge clk) begin
        pv_c    <= {pv_c[1:0], bus_c.mem_req_val && !bus_c.mem_req_type};
        pd_c[0] <= rom_c(bus_c.mem_req_addr[9:2]);
        pd_c[1] <= pd_c[0];
        pd_c[2] <= pd_c[1];
    end

    // One line per accepted memory transaction.
    always @(posedge clk) begin
        if (rst_n && bus_a.mem_req_val)
            $display("[%0t] a: type=%0d addr=%h wdata=%h", $time, bus_a.mem_req_type, bus_a.mem_req_addr, bus_a.mem_req_wdata);
        if (rst_n && bus_b.mem_req_val)
            $display("[%0t] b: type=%0d addr=%h", $time, bus_b.mem_req_type, bus_b.mem_req_addr);
        if (rst_n && bus_c.mem_req_val)
            $display("[%0t] c: type=%0d addr=%h", $time, bus_c.mem_req_type, bus_c.mem_req_addr);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.req_val = 2'b11;
        #1;
        n_cmp++; if (bus_a.req_rdy !== 2'b00) begin n_bad++; $display("FAIL rst_rdy: got %b want 00", bus_a.req_rdy); end
        n_cmp++; if (bus_a.mem_req_val !== 1'b0) begin n_bad++; $display("FAIL rst_memval: got %b want 0", bus_a.mem_req_val); end
        cyc();
        cyc();
        bus_a.req_val = 2'b00;
        rst_n = 1'b1;
        cyc();
        n_cmp++; if (bus_a.resp_val !== 2'b00) begin n_bad++; $display("FAIL idle_resp_a: got %b want 00", bus_a.resp_val); end
        n_cmp++; if (bus_b.resp_val !== 4'b0000) begin n_bad++; $display("FAIL idle_resp_b: got %b want 0000", bus_b.resp_val); end
        n_cmp++; if (bus_a.mem_req_val !== 1'b0) begin n_bad++; $display("FAIL idle_memval: got %b want 0", bus_a.mem_req_val); end
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", bus_a.busy); end
        n_cmp++; if (bus_c.busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy_c: got %b want 0", bus_c.busy); end
        n_cmp++; if (bus_a.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL idle_rdata: got %h want 0", bus_a.resp_rdata); end
    endtask

    task automatic test_write_read();
        bus_a.req_val   = 2'b01;
        bus_a.req_type  = 2'b01;
        bus_a.req_addr  = {32'h0, 32'h100};
        bus_a.req_wdata = {32'h0, 32'hDEADBEEF};
        #1;
        n_cmp++; if (bus_a.req_rdy !== 2'b01) begin n_bad++; $display("FAIL wr_rdy: got %b want 01", bus_a.req_rdy); end
        n_cmp++; if (bus_a.mem_req_type !== 1'b1) begin n_bad++; $display("FAIL wr_type: got %b want 1", bus_a.mem_req_type); end
        n_cmp++; if (bus_a.mem_req_addr !== 32'h100) begin n_bad++; $display("FAIL wr_addr: got %h want 100", bus_a.mem_req_addr); end
        n_cmp++; if (bus_a.mem_req_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_wdata: got %h want deadbeef", bus_a.mem_req_wdata); end
        cyc();
        bus_a.req_val   = 2'b10;
        bus_a.req_type  = 2'b00;
        bus_a.req_addr  = {32'h100, 32'h0};
        bus_a.req_wdata = '0;
        #1;
        n_cmp++; if (bus_a.resp_val !== 2'b01) begin n_bad++; $display("FAIL wr_ack: got %b want 01", bus_a.resp_val); end
        n_cmp++; if (bus_a.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL wr_ack_data: got %h want 0", bus_a.resp_rdata); end
        n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy: got %b want 1", bus_a.busy); end
        n_cmp++; if (bus_a.req_rdy !== 2'b10) begin n_bad++; $display("FAIL rd_rdy: got %b want 10", bus_a.req_rdy); end
        n_cmp++; if (bus_a.mem_req_type !== 1'b0) begin n_bad++; $display("FAIL rd_type: got %b want 0", bus_a.mem_req_type); end
        cyc();
        bus_a.req_val = 2'b00;
        #1;
        n_cmp++; if (bus_a.resp_val !== 2'b10) begin n_bad++; $display("FAIL rd_resp: got %b want 10", bus_a.resp_val); end
        n_cmp++; if (bus_a.resp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", bus_a.resp_rdata); end
        n_cmp++; if (bus_a.mem_req_val !== 1'b0) begin n_bad++; $display("FAIL nogrant_val: got %b want 0", bus_a.mem_req_val); end
        n_cmp++; if (bus_a.mem_req_addr !== 32'h0) begin n_bad++; $display("FAIL nogrant_addr: got %h want 0", bus_a.mem_req_addr); end
        cyc();
        n_cmp++; if (bus_a.resp_val !== 2'b00) begin n_bad++; $display("FAIL rd_one_cycle: got %b want 00", bus_a.resp_val); end
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL rd_idle_busy: got %b want 0", bus_a.busy); end
        n_cmp++; if (bus_a.resp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_hold: got %h want deadbeef", bus_a.resp_rdata); end
    endtask

    task automatic test_fixed_priority();
        bus_a.req_val  = 2'b11;
        bus_a.req_type = 2'b00;
        bus_a.req_addr = {32'h200, 32'h100};
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (bus_a.req_rdy !== 2'b01) begin n_bad++; $display("FAIL fix_rdy[%0d]: got %b want 01", k, bus_a.req_rdy); end
            if (k > 0) begin
                n_cmp++; if (bus_a.resp_val !== 2'b01) begin n_bad++; $display("FAIL fix_resp[%0d]: got %b want 01", k, bus_a.resp_val); end
                n_cmp++; if (bus_a.resp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fix_data[%0d]: got %h want deadbeef", k, bus_a.resp_rdata); end
            end
            cyc();
        end
        bus_a.req_val = 2'b10;
        #1;
        n_cmp++; if (bus_a.req_rdy !== 2'b10) begin n_bad++; $display("FAIL fix_ch1_rdy: got %b want 10", bus_a.req_rdy); end
        n_cmp++; if (bus_a.mem_req_addr !== 32'h200) begin n_bad++; $display("FAIL fix_ch1_addr: got %h want 200", bus_a.mem_req_addr); end
        cyc();
        bus_a.req_val = 2'b00;
        #1;
        n_cmp++; if (bus_a.resp_val !== 2'b10) begin n_bad++; $display("FAIL fix_ch1_resp: got %b want 10", bus_a.resp_val); end
        n_cmp++; if (bus_a.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL fix_ch1_data: got %h want 0", bus_a.resp_rdata); end
        cyc();
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_g;
        logic [31:0] exp_d;
        bus_b.req_val  = 4'hF;
        bus_b.req_type = 4'h0;
        for (int i = 0; i < 4; i++) bus_b.req_addr[i*32 +: 32] = 32'(i * 4);
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_g = 4'(1 << (k % 4));
            n_cmp++; if (bus_b.req_rdy !== exp_g) begin n_bad++; $display("FAIL rr_rdy[%0d]: got %b want %b", k, bus_b.req_rdy, exp_g); end
            if (k > 0) begin
                exp_g = 4'(1 << ((k - 1) % 4));
                exp_d = 32'hA0 + 32'((k - 1) % 4);
                n_cmp++; if (bus_b.resp_val !== exp_g) begin n_bad++; $display("FAIL rr_resp[%0d]: got %b want %b", k, bus_b.resp_val, exp_g); end
                n_cmp++; if (bus_b.resp_rdata !== exp_d) begin n_bad++; $display("FAIL rr_data[%0d]: got %h want %h", k, bus_b.resp_rdata, exp_d); end
            end
            cyc();
        end
        bus_b.req_val = 4'h0;
        #1;
        n_cmp++; if (bus_b.resp_val !== 4'b1000) begin n_bad++; $display("FAIL rr_last_resp: got %b want 1000", bus_b.resp_val); end
        n_cmp++; if (bus_b.resp_rdata !== 32'hA3) begin n_bad++; $display("FAIL rr_last_data: got %h want a3", bus_b.resp_rdata); end
        cyc();
    endtask

    task automatic test_latency();
        bus_c.req_val  = 4'b0100;
        bus_c.req_type = 4'h0;
        bus_c.req_addr = {32'h0, 32'h40, 32'h0, 32'h0};
        #1;
        n_cmp++; if (bus_c.req_rdy !== 4'b0100) begin n_bad++; $display("FAIL lat_rdy: got %b want 0100", bus_c.req_rdy); end
        n_cmp++; if (bus_c.mem_req_addr !== 32'h40) begin n_bad++; $display("FAIL lat_addr: got %h want 40", bus_c.mem_req_addr); end
        cyc();
        bus_c.req_val = 4'b0001;
        for (int k = 1; k <= 3; k++) begin
            #1;
            n_cmp++; if (bus_c.req_rdy !== 4'b0000) begin n_bad++; $display("FAIL wait_rdy[%0d]: got %b want 0000", k, bus_c.req_rdy); end
            n_cmp++; if (bus_c.busy !== 1'b1) begin n_bad++; $display("FAIL wait_busy[%0d]: got %b want 1", k, bus_c.busy); end
            n_cmp++; if (bus_c.resp_val !== 4'b0000) begin n_bad++; $display("FAIL wait_resp[%0d]: got %b want 0000", k, bus_c.resp_val); end
            cyc();
        end
        #1;
        n_cmp++; if (bus_c.resp_val !== 4'b0100) begin n_bad++; $display("FAIL lat_resp: got %b want 0100", bus_c.resp_val); end
        n_cmp++; if (bus_c.resp_rdata !== 32'h1234) begin n_bad++; $display("FAIL lat_data: got %h want 1234", bus_c.resp_rdata); end
        n_cmp++; if (bus_c.req_rdy !== 4'b0001) begin n_bad++; $display("FAIL lat_regrant: got %b want 0001", bus_c.req_rdy); end
        cyc();
        bus_c.req_val = 4'b0000;
        cyc();
        cyc();
        cyc();
        n_cmp++; if (bus_c.resp_val !== 4'b0001) begin n_bad++; $display("FAIL lat2_resp: got %b want 0001", bus_c.resp_val); end
        n_cmp++; if (bus_c.resp_rdata !== 32'h55) begin n_bad++; $display("FAIL lat2_data: got %h want 55", bus_c.resp_rdata); end
        cyc();
    endtask

    task automatic test_reset_in_wait();
        bus_c.req_val  = 4'b0010;
        bus_c.req_addr = {32'h0, 32'h0, 32'h40, 32'h0};
        #1;
        n_cmp++; if (bus_c.req_rdy !== 4'b0010) begin n_bad++; $display("FAIL rw_rdy: got %b want 0010", bus_c.req_rdy); end
        cyc();
        bus_c.req_val = 4'b0000;
        cyc();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus_c.busy !== 1'b0) begin n_bad++; $display("FAIL rw_busy: got %b want 0", bus_c.busy); end
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (bus_c.resp_val !== 4'b0000) begin n_bad++; $display("FAIL rw_noresp[%0d]: got %b want 0000", k, bus_c.resp_val); end
            n_cmp++; if (bus_c.busy !== 1'b0) begin n_bad++; $display("FAIL rw_idle[%0d]: got %b want 0", k, bus_c.busy); end
            cyc();
        end
        bus_c.req_val = 4'b1001;
        #1;
        n_cmp++; if (bus_c.req_rdy !== 4'b0001) begin n_bad++; $display("FAIL rw_ptr: got %b want 0001", bus_c.req_rdy); end
        cyc();
        bus_c.req_val = 4'b0000;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        bus_a.req_val = '0; bus_a.req_type = '0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
        bus_b.req_val = '0; bus_b.req_type = '0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
        bus_c.req_val = '0; bus_c.req_type = '0; bus_c.req_addr = '0; bus_c.req_wdata = '0;
        test_reset();
        test_write_read();
        test_fixed_priority();
        test_round_robin();
        test_latency();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
